// File: rtl/cols_to_px.sv
// Column-to-raster reorder: column beats fill one ping-pong bank while the other drains row-major, one pixel per beat.
// Latency: pixel 0 registered one edge after the last column; tready low only while both banks are full; output holds under stall.
module cols_to_px #(
   parameter int PX_WIDTH = 8,
   parameter int MAT_SIZE = 8
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic [((MAT_SIZE*PX_WIDTH+7)/8)*8-1:0]     video_i_tdata_i,
   input  logic                                       video_i_tvalid_i,
   output logic                                       video_i_tready_o,
   input  logic                                       video_i_tuser_i,
   input  logic                                       video_i_tlast_i,
   output logic [((PX_WIDTH+7)/8)*8-1:0]              video_o_tdata_o,
   output logic                                       video_o_tvalid_o,
   input  logic                                       video_o_tready_i,
   output logic                                       video_o_tuser_o,
   output logic                                       video_o_tlast_o,
   output logic [(PX_WIDTH+7)/8-1:0]                  video_o_tkeep_o,
   output logic [(PX_WIDTH+7)/8-1:0]                  video_o_tstrb_o
);

   localparam int OUT_W = ((PX_WIDTH + 7) / 8) * 8;
   localparam int LOG_M = $clog2(MAT_SIZE);
   localparam int IDX_W = 2 * LOG_M;
   localparam int NPX   = MAT_SIZE * MAT_SIZE;

   typedef enum logic [1:0] {
      WRITE_BUF_0_S,
      WAIT_BUF_1_EMPTY_S,
      WRITE_BUF_1_S,
      WAIT_BUF_0_EMPTY_S
   } wr_state_e;

   typedef enum logic [1:0] {
      WAIT_BUF_0_FULL_S,
      READ_BUF_0_S,
      WAIT_BUF_1_FULL_S,
      READ_BUF_1_S
   } rd_state_e;

   wr_state_e               wr_state_q, wr_state_d;
   rd_state_e               rd_state_q, rd_state_d;
   logic [LOG_M-1:0]        wr_col_q, wr_col_d;
   logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
   logic [1:0]              full_q, full_d;
   logic [1:0]              tuser_lock_q, tuser_lock_d;
   logic [1:0]              tlast_lock_q, tlast_lock_d;
   logic [PX_WIDTH-1:0]     out_dat_q, out_dat_d;
   logic                    out_vld_q, out_vld_d;
   logic                    out_usr_q, out_usr_d;
   logic                    out_lst_q, out_lst_d;
   logic [PX_WIDTH-1:0]     mem_q [2][MAT_SIZE][MAT_SIZE];

   logic                    wr_bank, rd_bank;
   logic                    wr_fire, wr_last, rd_fire, rd_last, dp_ready;
   logic [1:0]              full_set, full_clr, usr_set, lst_set;
   logic [LOG_M-1:0]        rd_row, rd_col;

   assign wr_bank  = (wr_state_q == WRITE_BUF_1_S) || (wr_state_q == WAIT_BUF_1_EMPTY_S);
   assign rd_bank  = (rd_state_q == READ_BUF_1_S)  || (rd_state_q == WAIT_BUF_1_FULL_S);
   assign video_i_tready_o = (wr_state_q == WRITE_BUF_0_S) || (wr_state_q == WRITE_BUF_1_S);
   assign wr_fire  = video_i_tready_o && video_i_tvalid_i;
   assign wr_last  = wr_fire && (wr_col_q == LOG_M'(MAT_SIZE - 1));
   assign dp_ready = !out_vld_q || video_o_tready_i;
   // A bank is readable exactly while its full flag is set, so a WAIT state can load pixel 0 on the same edge it leaves.
   assign rd_fire  = full_q[rd_bank] && dp_ready;
   assign rd_last  = rd_fire && (rd_idx_q == IDX_W'(NPX - 1));
   assign rd_row   = rd_idx_q[IDX_W-1:LOG_M];
   assign rd_col   = rd_idx_q[LOG_M-1:0];

   always_comb begin
      full_set = '0;
      full_clr = '0;
      usr_set  = '0;
      lst_set  = '0;
      if (wr_fire) begin
         if ((wr_col_q == '0) && video_i_tuser_i) usr_set[wr_bank] = 1'b1;
         if (video_i_tlast_i)                     lst_set[wr_bank] = 1'b1;
         if (wr_last)                             full_set[wr_bank] = 1'b1;
      end
      if (rd_last) full_clr[rd_bank] = 1'b1;
      full_d       = (full_q & ~full_clr) | full_set;
      tuser_lock_d = (tuser_lock_q & ~full_clr) | usr_set;
      tlast_lock_d = (tlast_lock_q & ~full_clr) | lst_set;
   end

   // Write side looks at full_d so a bank freed on this edge is writable on the very next cycle.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_col_d   = wr_col_q;
      if (wr_fire) wr_col_d = wr_last ? '0 : wr_col_q + LOG_M'(1);
      case (wr_state_q)
         WRITE_BUF_0_S:      if (wr_last) wr_state_d = full_d[1] ? WAIT_BUF_1_EMPTY_S : WRITE_BUF_1_S;
         WAIT_BUF_1_EMPTY_S: if (!full_d[1]) wr_state_d = WRITE_BUF_1_S;
         WRITE_BUF_1_S:      if (wr_last) wr_state_d = full_d[0] ? WAIT_BUF_0_EMPTY_S : WRITE_BUF_0_S;
         WAIT_BUF_0_EMPTY_S: if (!full_d[0]) wr_state_d = WRITE_BUF_0_S;
         default:            wr_state_d = WRITE_BUF_0_S;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_idx_d   = rd_idx_q;
      out_dat_d  = out_dat_q;
      out_vld_d  = out_vld_q;
      out_usr_d  = out_usr_q;
      out_lst_d  = out_lst_q;
      if (rd_fire) begin
         out_dat_d = mem_q[rd_bank][rd_row][rd_col];
         out_vld_d = 1'b1;
         out_usr_d = tuser_lock_q[rd_bank] && (rd_idx_q == '0);
         out_lst_d = tlast_lock_q[rd_bank] && rd_last;
         rd_idx_d  = rd_last ? '0 : rd_idx_q + IDX_W'(1);
      end else if (dp_ready) begin
         out_vld_d = 1'b0;
      end
      case (rd_state_q)
         WAIT_BUF_0_FULL_S: if (full_q[0]) rd_state_d = READ_BUF_0_S;
         READ_BUF_0_S:      if (rd_last) rd_state_d = full_q[1] ? READ_BUF_1_S : WAIT_BUF_1_FULL_S;
         WAIT_BUF_1_FULL_S: if (full_q[1]) rd_state_d = READ_BUF_1_S;
         READ_BUF_1_S:      if (rd_last) rd_state_d = full_q[0] ? READ_BUF_0_S : WAIT_BUF_0_FULL_S;
         default:           rd_state_d = WAIT_BUF_0_FULL_S;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_state_q   <= WRITE_BUF_0_S;
         rd_state_q   <= WAIT_BUF_0_FULL_S;
         wr_col_q     <= '0;
         rd_idx_q     <= '0;
         full_q       <= '0;
         tuser_lock_q <= '0;
         tlast_lock_q <= '0;
         out_dat_q    <= '0;
         out_vld_q    <= 1'b0;
         out_usr_q    <= 1'b0;
         out_lst_q    <= 1'b0;
      end else begin
         wr_state_q   <= wr_state_d;
         rd_state_q   <= rd_state_d;
         wr_col_q     <= wr_col_d;
         rd_idx_q     <= rd_idx_d;
         full_q       <= full_d;
         tuser_lock_q <= tuser_lock_d;
         tlast_lock_q <= tlast_lock_d;
         out_dat_q    <= out_dat_d;
         out_vld_q    <= out_vld_d;
         out_usr_q    <= out_usr_d;
         out_lst_q    <= out_lst_d;
      end
   end

   // Pixel storage needs no reset: a bank is only read after all its columns have been written.
   always_ff @(posedge clk_i) begin
      if (wr_fire) begin
         for (int k = 0; k < MAT_SIZE; k++) begin
            mem_q[wr_bank][LOG_M'(k)][wr_col_q] <= video_i_tdata_i[k*PX_WIDTH +: PX_WIDTH];
         end
      end
   end

   assign video_o_tdata_o  = OUT_W'(out_dat_q);
   assign video_o_tvalid_o = out_vld_q;
   assign video_o_tuser_o  = out_usr_q;
   assign video_o_tlast_o  = out_lst_q;
   assign video_o_tkeep_o  = '1;
   assign video_o_tstrb_o  = '1;

endmodule
